// File: rtl/ascii_int32_converter_if.sv
// Token character stream in, one converted integer plus error code out per token.
// The token producer is the master; the converter is the slave.
interface ascii_int32_converter_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  num_start;
  logic [7:0]            num_char;
  logic                  num_valid;
  logic                  num_end;
  logic                  result_valid;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_err;
  logic [1:0]            err_code;

  modport master (
    output num_start, num_char, num_valid, num_end,
    input  result_valid, result, result_err, err_code
  );

  modport slave (
    input  num_start, num_char, num_valid, num_end,
    output result_valid, result, result_err, err_code
  );
endinterface

// File: rtl/ascii_int32_converter.sv
// Decimal token ("-"? digits) to signed DATA_WIDTH integer; result_valid one cycle after num_end.
// One char per cycle with no stall; the producer waits on result_valid, so there is no backpressure.
module ascii_int32_converter #(
  parameter int DATA_WIDTH = 32,
  parameter bit SATURATE   = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  ascii_int32_converter_if.slave  io
);
  localparam int AW = DATA_WIDTH + 1;
  localparam int PW = DATA_WIDTH + 5;
  localparam logic [PW-1:0] LIM_POS = (PW'(1) << (DATA_WIDTH - 1)) - PW'(1);
  localparam logic [PW-1:0] LIM_NEG = PW'(1) << (DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t          state;
  logic [AW-1:0]   acc;
  logic            neg, bad, ovf;
  logic [7:0]      ndig;

  logic            restart, in_tok, keep;
  logic [AW-1:0]   b_acc, n_acc;
  logic            b_neg, b_bad, b_ovf, n_neg, n_bad, n_ovf;
  logic [7:0]      b_ndig, n_ndig;
  logic [PW-1:0]   prod, limit;
  logic [DATA_WIDTH-1:0] mag, value;
  logic [1:0]      n_err;

  always_comb begin
    restart = io.num_start & io.num_valid;
    in_tok  = (state == ACCUM) | restart;
    // Outside a live token the working state starts clean, so a bare num_end reports "empty".
    keep    = (state == ACCUM) & ~restart;
    b_acc   = keep ? acc  : '0;
    b_neg   = keep & neg;
    b_bad   = keep & bad;
    b_ovf   = keep & ovf;
    b_ndig  = keep ? ndig : 8'd0;

    limit = b_neg ? LIM_NEG : LIM_POS;
    prod  = ({4'b0, b_acc} << 3) + ({4'b0, b_acc} << 1) + {{AW{1'b0}}, io.num_char[3:0]};

    n_acc  = b_acc;
    n_neg  = b_neg;
    n_bad  = b_bad;
    n_ovf  = b_ovf;
    n_ndig = b_ndig;
    if (in_tok && io.num_valid) begin
      if (io.num_char == 8'h2D) begin
        if (restart) n_neg = 1'b1;
        else         n_bad = 1'b1;
      end else if (io.num_char >= 8'h30 && io.num_char <= 8'h39) begin
        if (b_ndig != 8'hFF) n_ndig = b_ndig + 8'd1;
        if (!b_ovf) begin
          if (prod > limit) begin
            n_ovf = 1'b1;
            n_acc = limit[AW-1:0];
          end else begin
            n_acc = prod[AW-1:0];
          end
        end
      end else begin
        n_bad = 1'b1;
      end
    end

    if (n_bad)              n_err = 2'b01;
    else if (n_ndig == 8'd0) n_err = 2'b11;
    else if (n_ovf)         n_err = 2'b10;
    else                    n_err = 2'b00;

    mag = n_acc[DATA_WIDTH-1:0];
    if (n_err == 2'b00)                 value = n_neg ? (~mag + 1'b1) : mag;
    else if (n_err == 2'b10 && SATURATE) value = n_neg ? MIN_V : MAX_V;
    else                                value = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      acc             <= '0;
      neg             <= 1'b0;
      bad             <= 1'b0;
      ovf             <= 1'b0;
      ndig            <= 8'd0;
      io.result_valid <= 1'b0;
      io.result       <= '0;
      io.result_err   <= 1'b0;
      io.err_code     <= 2'b00;
    end else begin
      acc             <= n_acc;
      neg             <= n_neg;
      bad             <= n_bad;
      ovf             <= n_ovf;
      ndig            <= n_ndig;
      io.result_valid <= 1'b0;
      if (io.num_end) begin
        state           <= EMIT;
        io.result_valid <= 1'b1;
        io.result       <= value;
        io.err_code     <= n_err;
        io.result_err   <= (n_err != 2'b00);
      end else if (in_tok) begin
        state <= ACCUM;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ascii_int32_converter.sv
// Bench for ascii_int32_converter: token table plus corner sequences, checked via expectation queue.
module tb_ascii_int32_converter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascii_int32_converter_if #(.DATA_WIDTH(W)) bus ();
  ascii_int32_converter_if #(.DATA_WIDTH(W)) bus0 ();

  assign bus0.num_start = bus.num_start;
  assign bus0.num_char  = bus.num_char;
  assign bus0.num_valid = bus.num_valid;
  assign bus0.num_end   = bus.num_end;

  ascii_int32_converter #(.DATA_WIDTH(W), .SATURATE(1'b1)) dut_sat (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  ascii_int32_converter #(.DATA_WIDTH(W), .SATURATE(1'b0)) dut_zero (
    .clk (clk),
    .rst (rst),
    .io  (bus0)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] res0;
    logic [1:0]  err;
    int          cyc;
  } exp_t;

  typedef struct {
    string       tok;
    logic [31:0] res;
    logic [31:0] res0;
    logic [1:0]  err;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t q[$];
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.result_valid === 1'b1 || bus0.result_valid === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got result_valid=1 at cycle %0d expected no pulse", cyc);
      end else begin
        e = q.pop_front();
        chk("result",     bus.result,        e.res);
        chk("result_sat0", bus0.result,      e.res0);
        chk("err_code",   {30'd0, bus.err_code}, {30'd0, e.err});
        chk("result_err", {31'd0, bus.result_err}, {31'd0, (e.err != 2'b00)});
        chk("valid_sat0", {31'd0, bus0.result_valid}, 32'd1);
        chk("latency",    cyc, e.cyc);
      end
    end
  end

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_char(byte c, bit st);
    bus.num_valid = 1'b1;
    bus.num_char  = c;
    bus.num_start = st;
    idle_cycle();
    bus.num_valid = 1'b0;
    bus.num_start = 1'b0;
    bus.num_char  = 8'h00;
  endtask

  task automatic push_exp(logic [31:0] r, logic [31:0] r0, logic [1:0] er);
    exp_t x;
    x.res  = r;
    x.res0 = r0;
    x.err  = er;
    x.cyc  = cyc + 1;
    q.push_back(x);
  endtask

  task automatic send(string s, logic [31:0] r, logic [31:0] r0, logic [1:0] er);
    for (int i = 0; i < s.len(); i++) drive_char(s[i], (i == 0));
    bus.num_end = 1'b1;
    push_exp(r, r0, er);
    idle_cycle();
    bus.num_end = 1'b0;
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{"123",          32'd123,        32'd123,        2'b00};
    tbl[1]  = '{"-2147483648",  32'h8000_0000,  32'h8000_0000,  2'b00};
    tbl[2]  = '{"2147483648",   32'h7FFF_FFFF,  32'h0,          2'b10};
    tbl[3]  = '{"2147483647",   32'h7FFF_FFFF,  32'h7FFF_FFFF,  2'b00};
    tbl[4]  = '{"-2147483649",  32'h8000_0000,  32'h0,          2'b10};
    tbl[5]  = '{"1-2",          32'h0,          32'h0,          2'b01};
    tbl[6]  = '{"-",            32'h0,          32'h0,          2'b11};
    tbl[7]  = '{"007",          32'd7,          32'd7,          2'b00};
    tbl[8]  = '{"-0",           32'h0,          32'h0,          2'b00};
    tbl[9]  = '{"-45",          32'hFFFF_FFD3,  32'hFFFF_FFD3,  2'b00};
    tbl[10] = '{"12 ",          32'h0,          32'h0,          2'b01};
    tbl[11] = '{"99999999999999", 32'h7FFF_FFFF, 32'h0,         2'b10};
    tbl[12] = '{"99999999999x", 32'h0,          32'h0,          2'b01};
    tbl[13] = '{"--1",          32'h0,          32'h0,          2'b01};
    tbl[14] = '{"",             32'h0,          32'h0,          2'b11};

    rst           = 1'b1;
    bus.num_start = 1'b0;
    bus.num_char  = 8'h00;
    bus.num_valid = 1'b0;
    bus.num_end   = 1'b0;
    repeat (3) idle_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid",  {31'd0, bus.result_valid}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_err",    {31'd0, bus.result_err}, 32'd0);
    chk("rst_code",   {30'd0, bus.err_code}, 32'd0);
    idle_cycle();

    foreach (tbl[i]) begin
      send(tbl[i].tok, tbl[i].res, tbl[i].res0, tbl[i].err);
      idle_cycle();
    end

    // Outputs hold their last value between pulses.
    repeat (3) idle_cycle();
    chk("hold_result", bus.result, 32'h0);
    chk("hold_code",   {30'd0, bus.err_code}, 32'd3);
    send("-45", 32'hFFFF_FFD3, 32'hFFFF_FFD3, 2'b00);
    repeat (4) idle_cycle();
    chk("hold_result2", bus.result, 32'hFFFF_FFD3);

    // Back-to-back: next token starts while the previous result is emitted.
    send("5", 32'd5, 32'd5, 2'b00);
    send("6", 32'd6, 32'd6, 2'b00);
    idle_cycle();

    // Last char and num_end in the same cycle.
    drive_char("1", 1'b1);
    bus.num_valid = 1'b1;
    bus.num_char  = "2";
    bus.num_end   = 1'b1;
    push_exp(32'd12, 32'd12, 2'b00);
    idle_cycle();
    bus.num_valid = 1'b0;
    bus.num_end   = 1'b0;
    idle_cycle();

    // Restart mid-token discards the partial token.
    drive_char("7", 1'b1);
    drive_char("7", 1'b0);
    send("3", 32'd3, 32'd3, 2'b00);
    idle_cycle();

    // Reset mid-token: no pulse, outputs cleared, next token clean.
    drive_char("9", 1'b1);
    drive_char("9", 1'b0);
    rst = 1'b1;
    idle_cycle();
    rst = 1'b0;
    repeat (3) idle_cycle();
    chk("rst_mid_result", bus.result, 32'd0);
    send("4", 32'd4, 32'd4, 2'b00);

    repeat (5) idle_cycle();
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
